// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receive controller: default widths, the
// parity-type encodings and the frame-sequencing state enum.
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int PRESC_W_DEF = 6;   // oversampling ratio up to 32
    localparam int DATA_W_DEF  = 8;   // data bits per frame

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/edge_bit_counter.sv
// -----------------------------------------------------------------------------
// edge_bit_counter
// Oversample edge counter and data-bit counter for the UART receiver.
//   CLK, RST      : clock, asynchronous active-low reset
//   enable        : edge counter runs; held at 0 when low
//   clear         : zero both counters (start of a new frame)
//   bit_inc       : advance the bit counter by one
//   Prescale_lat  : latched oversampling ratio; edge_cnt wraps at Prescale_lat-1
//   edge_cnt      : oversample index within the current bit
//   bit_cnt       : number of data bits shifted so far in this frame
//   bit_end       : edge_cnt is on the last oversample of the bit
// -----------------------------------------------------------------------------
module edge_bit_counter #(
    parameter int PRESC_W = 6,
    parameter int CNT_W   = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               enable,
    input  logic               clear,
    input  logic               bit_inc,
    input  logic [PRESC_W-1:0] Prescale_lat,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [CNT_W-1:0]   bit_cnt,
    output logic               bit_end
);

    // Prescale_lat is 0 only while idle after reset; the counter is disabled
    // then, so the wrapped compare value is never acted upon.
    assign bit_end = (edge_cnt == (Prescale_lat - PRESC_W'(1)));

    // NOTE: reset is asynchronous (in the sensitivity list) and all state is
    // updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (clear) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            if (!enable || bit_end) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + PRESC_W'(1);
            end
            if (bit_inc) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Frame-level controller for the UART receive path: start detection, bit
// timing, deserializer sequencing and start/parity/stop checking.
//   CLK, RST       : clock, asynchronous active-low reset
//   RX_IN          : raw serial line, idle high
//   sampled_bit    : majority-voted bit, valid when edge_cnt == Prescale-1
//   PAR_EN/PAR_TYP : parity present / 0 even, 1 odd
//   Prescale       : oversampling ratio (8, 16, 32), latched at start detect
//   dat_samp_en    : data sampler enable (any state but IDLE)
//   edge_cnt       : oversample index within the current bit
//   deser_New_bit  : one-cycle shift strobe, once per data bit
//   deser_en       : one-cycle parallel-load enable for a good frame
//   data_valid     : one-cycle good-frame pulse
//   par_err        : parity mismatch, sticky until the next start
//   stop_err       : stop bit low, sticky until the next start
//   strt_glitch    : one-cycle pulse when a start bit is rejected
//   busy           : high in every state except IDLE
// -----------------------------------------------------------------------------
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W = PRESC_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic               sampled_bit,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic [PRESC_W-1:0] Prescale,
    output logic               dat_samp_en,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic               deser_New_bit,
    output logic               deser_en,
    output logic               data_valid,
    output logic               par_err,
    output logic               stop_err,
    output logic               strt_glitch,
    output logic               busy
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    rx_state_e          state;
    rx_state_e          next_state;
    logic [PRESC_W-1:0] presc_lat;
    logic [CNT_W-1:0]   bit_cnt;
    logic               bit_end;
    logic               par_acc;
    logic               start_det;
    logic               last_bit;

    assign start_det     = (state == IDLE) && !RX_IN;
    assign deser_New_bit = (state == DATA) && bit_end;
    assign last_bit      = deser_New_bit && (bit_cnt == CNT_W'(DATA_W - 1));
    assign dat_samp_en   = (state != IDLE);

    edge_bit_counter #(
        .PRESC_W (PRESC_W),
        .CNT_W   (CNT_W)
    ) u_counter (
        .CLK          (CLK),
        .RST          (RST),
        .enable       (state != IDLE),
        .clear        (start_det),
        .bit_inc      (deser_New_bit),
        .Prescale_lat (presc_lat),
        .edge_cnt     (edge_cnt),
        .bit_cnt      (bit_cnt),
        .bit_end      (bit_end)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: next_state gets its default before the case so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!RX_IN) next_state = START;
            end
            START: begin
                if (bit_end) next_state = sampled_bit ? IDLE : DATA;
            end
            DATA: begin
                if (last_bit) next_state = PAR_EN ? PARITY : STOP;
            end
            PARITY: begin
                if (bit_end) next_state = STOP;
            end
            STOP: begin
                if (bit_end) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            presc_lat   <= '0;
            par_acc     <= 1'b0;
            par_err     <= 1'b0;
            stop_err    <= 1'b0;
            data_valid  <= 1'b0;
            deser_en    <= 1'b0;
            strt_glitch <= 1'b0;
            busy        <= 1'b0;
        end else begin
            busy        <= (next_state != IDLE);
            strt_glitch <= (state == START) && bit_end && sampled_bit;
            // par_err already reflects this frame by the stop bit (cleared at
            // start, updated at the parity bit when present).
            data_valid  <= (state == STOP) && bit_end && sampled_bit && !par_err;
            deser_en    <= (state == STOP) && bit_end && sampled_bit && !par_err;

            if (start_det) begin
                presc_lat <= Prescale;
                par_acc   <= 1'b0;
                par_err   <= 1'b0;
                stop_err  <= 1'b0;
            end else begin
                if (deser_New_bit) begin
                    par_acc <= par_acc ^ sampled_bit;
                end
                if ((state == PARITY) && bit_end) begin
                    par_err <= sampled_bit != (par_acc ^ (PAR_TYP == PAR_ODD));
                end
                if ((state == STOP) && bit_end) begin
                    stop_err <= ~sampled_bit;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Directed and randomized frames for uart_rx_ctrl. The bench plays the line and
// the data sampler: in every cycle it presents the bit that belongs to the
// current oversample window, and predicts strobes, flags and pulses from frame
// arithmetic (bit index = cycle / Prescale).
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    localparam int PRESC_W = 6;
    localparam int DATA_W  = 8;

    logic               CLK = 1'b0;
    logic               RST;
    logic               RX_IN;
    logic               sampled_bit;
    logic               PAR_EN;
    logic               PAR_TYP;
    logic [PRESC_W-1:0] Prescale;
    logic               dat_samp_en;
    logic [PRESC_W-1:0] edge_cnt;
    logic               deser_New_bit;
    logic               deser_en;
    logic               data_valid;
    logic               par_err;
    logic               stop_err;
    logic               strt_glitch;
    logic               busy;

    int checks   = 0;
    int failures = 0;

    uart_rx_ctrl #(.PRESC_W(PRESC_W), .DATA_W(DATA_W)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .RX_IN         (RX_IN),
        .sampled_bit   (sampled_bit),
        .PAR_EN        (PAR_EN),
        .PAR_TYP       (PAR_TYP),
        .Prescale      (Prescale),
        .dat_samp_en   (dat_samp_en),
        .edge_cnt      (edge_cnt),
        .deser_New_bit (deser_New_bit),
        .deser_en      (deser_en),
        .data_valid    (data_valid),
        .par_err       (par_err),
        .stop_err      (stop_err),
        .strt_glitch   (strt_glitch),
        .busy          (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference rules: frame length and the flags a frame must produce.
    function automatic int frame_len(input int p, input bit pe);
        return p * (2 + DATA_W + int'(pe));
    endfunction

    function automatic bit exp_par_err(input bit pe, input bit pt, input logic [7:0] d, input bit pbit);
        return pe && (pbit != ((^d) ^ pt));
    endfunction

    function automatic logic [31:0] all_outputs();
        return {15'd0, dat_samp_en, deser_New_bit, deser_en, data_valid,
                par_err, stop_err, strt_glitch, busy, 3'd0, edge_cnt};
    endfunction

    // Called at a negedge with the DUT idle (or in its data_valid cycle).
    // abort_at >= 0 asserts reset asynchronously in that cycle and returns.
    task automatic run_frame(input string tag, input logic [7:0] d, input bit pbit, input bit stopb,
                             input int p, input bit pe, input bit pt, input int abort_at);
        logic bits[$];
        int   len;
        bit   e_pe, e_se, good;
        int   strobes = 0, strobe_bad = 0, ec_bad = 0, busy_bad = 0;
        int   dv_cnt = 0, de_cnt = 0, gl_cnt = 0;
        logic dv_end = 1'b0, de_end = 1'b0;
        logic [7:0] got = '0;
        logic v;

        bits.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) bits.push_back(d[i]);
        if (pe) bits.push_back(pbit);
        bits.push_back(stopb);
        len  = frame_len(p, pe);
        e_pe = exp_par_err(pe, pt, d, pbit);
        e_se = !stopb;
        good = !e_pe && !e_se;

        PAR_EN = pe; PAR_TYP = pt; Prescale = PRESC_W'(p);
        RX_IN = 1'b0; sampled_bit = 1'b0;

        for (int c = 0; c <= len; c++) begin
            @(negedge CLK);
            v = (c < len) ? bits[c / p] : 1'b1;
            if (c == 0) begin
                check({tag, " err_clear_on_start"}, {30'd0, par_err, stop_err}, 32'd0);
            end
            if (edge_cnt !== PRESC_W'((c < len) ? c % p : 0)) ec_bad++;
            if (busy !== (c < len) || dat_samp_en !== (c < len)) busy_bad++;
            if (deser_New_bit !== ((c < len) && (c % p == p - 1) && (c / p >= 1) && (c / p <= DATA_W)))
                strobe_bad++;
            if (deser_New_bit === 1'b1) begin
                if (strobes < DATA_W) got[strobes] = v;
                strobes++;
            end
            if (data_valid === 1'b1) dv_cnt++;
            if (deser_en === 1'b1) de_cnt++;
            if (strt_glitch === 1'b1) gl_cnt++;
            if (c == len) begin
                dv_end = data_valid;
                de_end = deser_en;
            end
            RX_IN = v; sampled_bit = v;
            // A mid-frame Prescale change must be ignored.
            if (c == 0) Prescale = PRESC_W'((p == 8) ? 16 : 8);
            if (c == abort_at) begin
                #2 RST = 1'b0;
                #1 check({tag, " outputs_in_reset"}, all_outputs(), 32'd0);
                check({tag, " no_dv_before_reset"}, dv_cnt, 0);
                return;
            end
        end

        check({tag, " strobe_count"}, strobes, DATA_W);
        check({tag, " strobe_timing"}, strobe_bad, 0);
        check({tag, " shifted_data"}, got, d);
        check({tag, " edge_cnt_trace"}, ec_bad, 0);
        check({tag, " busy_trace"}, busy_bad, 0);
        check({tag, " data_valid_at_latency"}, dv_end, good);
        check({tag, " data_valid_count"}, dv_cnt, int'(good));
        check({tag, " deser_en_at_latency"}, de_end, good);
        check({tag, " deser_en_count"}, de_cnt, int'(good));
        check({tag, " par_err"}, par_err, e_pe);
        check({tag, " stop_err"}, stop_err, e_se);
        check({tag, " no_glitch"}, gl_cnt, 0);
    endtask

    // One idle cycle after a frame: pulses gone, sticky flags held.
    task automatic idle_check(input string tag, input bit e_pe, input bit e_se);
        RX_IN = 1'b1; sampled_bit = 1'b1;
        @(negedge CLK);
        check({tag, " idle_pulses_low"}, {29'd0, data_valid, deser_en, busy}, 32'd0);
        check({tag, " idle_sticky_flags"}, {30'd0, par_err, stop_err}, {30'd0, e_pe, e_se});
    endtask

    // RX_IN low for three cycles, then high; sampler votes 1 at the bit centre.
    task automatic run_glitch(input string tag, input int p);
        int gl_cnt = 0, strobes = 0, busy_bad = 0, ec_bad = 0, dv_cnt = 0;
        logic gl_at_end = 1'b0;
        Prescale = PRESC_W'(p);
        RX_IN = 1'b0; sampled_bit = 1'b0;
        for (int c = 0; c <= p + 1; c++) begin
            @(negedge CLK);
            if (strt_glitch === 1'b1) gl_cnt++;
            if (c == p) gl_at_end = strt_glitch;
            if (deser_New_bit === 1'b1) strobes++;
            if (data_valid === 1'b1 || deser_en === 1'b1) dv_cnt++;
            if (busy !== (c < p)) busy_bad++;
            if (edge_cnt !== PRESC_W'((c < p) ? c : 0)) ec_bad++;
            RX_IN = (c >= 2); sampled_bit = (c >= 2);
        end
        check({tag, " glitch_count"}, gl_cnt, 1);
        check({tag, " glitch_after_last_edge"}, gl_at_end, 1'b1);
        check({tag, " no_strobes"}, strobes, 0);
        check({tag, " no_valid"}, dv_cnt, 0);
        check({tag, " busy_trace"}, busy_bad, 0);
        check({tag, " edge_cnt_trace"}, ec_bad, 0);
    endtask

    initial begin
        logic [7:0] d;
        int         p;
        bit         pe, pt, pbit, stopb;

        RST = 1'b0; RX_IN = 1'b1; sampled_bit = 1'b1;
        PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
        repeat (3) @(negedge CLK);
        check("reset_outputs", all_outputs(), 32'd0);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check("idle_after_reset", all_outputs(), 32'd0);

        // Good frame 0xA5, even parity (bit 0), Prescale 8: valid 88 cycles after start.
        run_frame("a5_even", 8'hA5, 1'b0, 1'b1, 8, 1'b1, 1'b0, -1);
        idle_check("a5_even", 1'b0, 1'b0);

        // Same frame with a wrong parity bit; flag cleared by the next start.
        run_frame("a5_bad_par", 8'hA5, 1'b1, 1'b1, 8, 1'b1, 1'b0, -1);
        idle_check("a5_bad_par", 1'b1, 1'b0);

        // Prescale 16, no parity, stop bit low.
        run_frame("3c_bad_stop", 8'h3C, 1'b0, 1'b0, 16, 1'b0, 1'b0, -1);
        idle_check("3c_bad_stop", 1'b0, 1'b1);

        run_glitch("glitch_p8", 8);

        // Back-to-back, odd parity, no idle gap.
        run_frame("b2b_01", 8'h01, 1'b0, 1'b1, 8, 1'b1, 1'b1, -1);
        run_frame("b2b_ff", 8'hFF, 1'b1, 1'b1, 8, 1'b1, 1'b1, -1);
        idle_check("b2b_ff", 1'b0, 1'b0);

        // Reset in the middle of data bit 4, then a clean frame.
        run_frame("abort", 8'hC3, 1'b0, 1'b1, 8, 1'b1, 1'b0, 5 * 8 + 3);
        RX_IN = 1'b1; sampled_bit = 1'b1;
        @(negedge CLK);
        check("outputs_held_in_reset", all_outputs(), 32'd0);
        RST = 1'b1;
        @(negedge CLK);
        run_frame("5a_after_reset", 8'h5A, 1'b0, 1'b1, 8, 1'b1, 1'b0, -1);
        idle_check("5a_after_reset", 1'b0, 1'b0);

        // Randomized frames: ratio, parity mode, data, occasional bad parity/stop.
        for (int n = 0; n < 12; n++) begin
            d     = 8'($urandom);
            p     = 8 << $urandom_range(0, 2);
            pe    = 1'($urandom_range(0, 1));
            pt    = 1'($urandom_range(0, 1));
            pbit  = ((^d) ^ pt) ^ ($urandom_range(0, 3) == 0);
            stopb = ($urandom_range(0, 3) != 0);
            run_frame($sformatf("rand%0d", n), d, pbit, stopb, p, pe, pt, -1);
            repeat ($urandom_range(0, 3)) begin
                RX_IN = 1'b1; sampled_bit = 1'b1;
                @(negedge CLK);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
